// File: rtl/bcd_counter_chain_pkg.sv
// Shared definitions for the cascaded modulo-RADIX counter: limit-mode
// constants and packed-digit helpers.
package bcd_counter_chain_pkg;

    localparam int unsigned SAT_WRAP = 0;
    localparam int unsigned SAT_HOLD = 1;

    // Minimum bits needed to hold digit values 0..radix-1.
    function automatic int unsigned digit_width(input int unsigned radix);
        return (radix <= 2) ? 1 : $clog2(radix);
    endfunction

    // LSB position of digit idx inside a packed digit vector.
    function automatic int unsigned digit_lsb(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_digit.sv
// Single modulo-RADIX up/down digit with clear, clamped load and step enable.
module bcd_digit #(
    parameter int unsigned RADIX = 10,
    parameter int unsigned DW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          up,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    output logic [DW-1:0] value,
    output logic          at_limit
);

    localparam int unsigned DWX = DW + 1;
    localparam logic [DW-1:0]  MAX_DIG = DW'(RADIX - 1);
    localparam logic [DWX-1:0] RADIX_X = DWX'(RADIX);

    logic [DW-1:0] value_d, value_q;

    assign value    = value_q;
    assign at_limit = up ? (value_q == MAX_DIG) : (value_q == '0);

    // Out-of-range load digits clamp so no value >= RADIX is ever stored.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = ({1'b0, load_digit} >= RADIX_X) ? MAX_DIG : load_digit;
        end else if (step) begin
            if (up) begin
                value_d = (value_q == MAX_DIG) ? '0 : value_q + DW'(1);
            end else begin
                value_d = (value_q == '0) ? MAX_DIG : value_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit cascaded up/down counter with terminal carry, wrap/saturate
// limit handling and a sticky overflow flag.
module bcd_counter_chain
    import bcd_counter_chain_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned RADIX    = 10,
    parameter int unsigned DW       = 4,
    parameter int unsigned SATURATE = SAT_WRAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 up,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic                 carry,
    output logic                 ovf
);

    logic [DIGITS-1:0] at_limit;
    logic [DIGITS-1:0] step_c;
    logic [DIGITS-1:0] lower_mask;
    logic              hold_c;
    logic              ovf_d, ovf_q;

    assign carry  = en & ~clr & ~load & (&at_limit);
    assign hold_c = (SATURATE == SAT_HOLD) ? carry : 1'b0;
    assign ovf    = ovf_q;

    // Digit i steps only when every lower digit sits at its limit.
    always_comb begin
        step_c     = '0;
        lower_mask = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            lower_mask = (DIGITS'(1) << i) - DIGITS'(1);
            step_c[i]  = en & ~hold_c & (&(at_limit | ~lower_mask));
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (carry) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit #(
            .RADIX (RADIX),
            .DW    (DW)
        ) u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .step       (step_c[g]),
            .up         (up),
            .clr        (clr),
            .load       (load),
            .load_digit (load_val[digit_lsb(g, DW) +: DW]),
            .value      (count[digit_lsb(g, DW) +: DW]),
            .at_limit   (at_limit[g])
        );
    end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain: decimal wrap, saturate and hex variants.
module tb_bcd_counter_chain;

    logic clk = 1'b0;
    logic rst_n;

    logic        d_en, d_up, d_clr, d_load;
    logic [15:0] d_load_val, d_count;
    logic        d_carry, d_ovf;

    logic        s_en, s_up, s_clr, s_load;
    logic [15:0] s_load_val, s_count;
    logic        s_carry, s_ovf;

    logic        h_en, h_up, h_clr, h_load;
    logic [7:0]  h_load_val, h_count;
    logic        h_carry, h_ovf;

    int errors = 0;
    int checks = 0;
    int carry_hits;

    always #5 clk = ~clk;

    bcd_counter_chain u_dec (
        .clk(clk), .rst_n(rst_n), .en(d_en), .up(d_up), .clr(d_clr), .load(d_load),
        .load_val(d_load_val), .count(d_count), .carry(d_carry), .ovf(d_ovf)
    );

    bcd_counter_chain #(.SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load),
        .load_val(s_load_val), .count(s_count), .carry(s_carry), .ovf(s_ovf)
    );

    bcd_counter_chain #(.DIGITS(2), .RADIX(16), .DW(4)) u_hex (
        .clk(clk), .rst_n(rst_n), .en(h_en), .up(h_up), .clr(h_clr), .load(h_load),
        .load_val(h_load_val), .count(h_count), .carry(h_carry), .ovf(h_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {d_en, d_up, d_clr, d_load} = '0; d_load_val = '0;
        {s_en, s_up, s_clr, s_load} = '0; s_load_val = '0;
        {h_en, h_up, h_clr, h_load} = '0; h_load_val = '0;
        #2;
        check("rst_count", 32'(d_count), 32'h0);
        check("rst_ovf",   32'(d_ovf),   32'h0);
        check("rst_carry", 32'(d_carry), 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Count up 1234 steps from reset
        d_en = 1'b1; d_up = 1'b1;
        carry_hits = 0;
        repeat (1234) begin
            tick();
            if (d_carry) carry_hits++;
        end
        d_en = 1'b0;
        check("up1234_count", 32'(d_count), 32'h1234);
        check("up1234_carry", 32'(carry_hits), 32'd0);
        check("up1234_ovf",   32'(d_ovf), 32'h0);

        // Wrap up from 9999
        d_load = 1'b1; d_load_val = 16'h9999;
        tick();
        d_load = 1'b0;
        check("load9999", 32'(d_count), 32'h9999);
        d_en = 1'b1; d_up = 1'b1;
        #1;
        check("wrapup_carry", 32'(d_carry), 32'h1);
        tick();
        d_en = 1'b0;
        check("wrapup_count", 32'(d_count), 32'h0000);
        check("wrapup_ovf",   32'(d_ovf),   32'h1);
        #1;
        check("idle_carry", 32'(d_carry), 32'h0);

        // Wrap down from 0000
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        check("clr_count", 32'(d_count), 32'h0);
        check("clr_ovf",   32'(d_ovf),   32'h0);
        d_en = 1'b1; d_up = 1'b0;
        #1;
        check("wrapdn_carry", 32'(d_carry), 32'h1);
        tick();
        d_en = 1'b0;
        check("wrapdn_count", 32'(d_count), 32'h9999);
        check("wrapdn_ovf",   32'(d_ovf),   32'h1);

        // Borrow across digits
        d_load = 1'b1; d_load_val = 16'h1000;
        tick();
        d_load = 1'b0; d_en = 1'b1; d_up = 1'b0;
        #1;
        check("borrow_carry", 32'(d_carry), 32'h0);
        tick();
        d_en = 1'b0;
        check("borrow_count", 32'(d_count), 32'h0999);

        // Load beats en, out-of-range digits clamp, ovf untouched
        d_load = 1'b1; d_en = 1'b1; d_up = 1'b1; d_load_val = 16'h0A5F;
        #1;
        check("load_en_carry", 32'(d_carry), 32'h0);
        tick();
        d_load = 1'b0; d_en = 1'b0;
        check("clamp_count", 32'(d_count), 32'h0959);
        check("clamp_ovf",   32'(d_ovf),   32'h1);

        // Clear beats load
        d_clr = 1'b1; d_load = 1'b1; d_load_val = 16'h1234;
        tick();
        d_clr = 1'b0; d_load = 1'b0;
        check("clrload_count", 32'(d_count), 32'h0);
        check("clrload_ovf",   32'(d_ovf),   32'h0);

        // Async reset mid-count, with ovf set beforehand
        d_load = 1'b1; d_load_val = 16'h9999;
        tick();
        d_load = 1'b0; d_en = 1'b1; d_up = 1'b1;
        tick();
        d_en = 1'b0; d_load = 1'b1; d_load_val = 16'h0420;
        tick();
        d_load = 1'b0; d_en = 1'b1;
        tick();
        check("pre_rst_count", 32'(d_count), 32'h0421);
        check("pre_rst_ovf",   32'(d_ovf),   32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(d_count), 32'h0);
        check("async_rst_ovf",   32'(d_ovf),   32'h0);
        rst_n = 1'b1;
        tick();
        d_en = 1'b0;
        check("resume_count", 32'(d_count), 32'h0001);

        // Saturating instance holds at the limits
        s_load = 1'b1; s_load_val = 16'h9998;
        tick();
        s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
        #1;
        check("sat_c1_carry", 32'(s_carry), 32'h0);
        tick();
        check("sat_c1_count", 32'(s_count), 32'h9999);
        check("sat_c2_carry", 32'(s_carry), 32'h1);
        tick();
        check("sat_c2_count", 32'(s_count), 32'h9999);
        check("sat_c3_carry", 32'(s_carry), 32'h1);
        check("sat_c2_ovf",   32'(s_ovf),   32'h1);
        tick();
        s_en = 1'b0;
        check("sat_c3_count", 32'(s_count), 32'h9999);
        check("sat_c3_ovf",   32'(s_ovf),   32'h1);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0; s_en = 1'b1; s_up = 1'b0;
        #1;
        check("satdn_carry", 32'(s_carry), 32'h1);
        tick();
        s_en = 1'b0;
        check("satdn_count", 32'(s_count), 32'h0);
        check("satdn_ovf",   32'(s_ovf),   32'h1);

        // Two hex digits: 256 steps return to 00 with one carry
        h_en = 1'b1; h_up = 1'b1;
        carry_hits = 0;
        repeat (256) begin
            if (h_carry) carry_hits++;
            tick();
        end
        h_en = 1'b0;
        check("hex_count",  32'(h_count),   32'h00);
        check("hex_carries", 32'(carry_hits), 32'd1);
        check("hex_ovf",    32'(h_ovf),     32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised multi-digit cascaded counter, the successor to the single 4-bit enable counter used to drive the seven-segment display path. It counts up or down in a configurable radix (decimal by default) across DIGITS digits, supports synchronous clear and parallel load, and offers wrap or saturate behaviour at the limits. It reports a terminal-count carry and a sticky overflow flag. Its packed digit output feeds the seven-segment multiplexer/decoder directly.

## Interface

Parameters:
- DIGITS, 4, number of cascaded digits (1..8).
- RADIX, 10, modulus of each digit (2..16).
- DW, 4, bits per digit; must satisfy 2^DW >= RADIX.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- load_val  in  DIGITS*DW  load value; digit i occupies bits [i*DW +: DW], digit 0 least significant.
- count  out  DIGITS*DW  current value, same packing as load_val.
- carry  out  1  terminal-count indication (combinational).
- ovf  out  1  sticky overflow/underflow flag (registered).

## Operation

- Reset (rst_n low, asynchronous): count = 0 and ovf = 0. Since carry is derived from count, it also reads 0 with en low.
- Per-cycle priority is clr > load > en.
  - clr: count = 0, ovf = 0.
  - load: each digit takes its load_val digit. Any digit >= RADIX is clamped to RADIX-1. ovf is unchanged.
  - en with up=1: digit 0 increments. Digit i increments only when all lower digits equal RADIX-1. Every digit at RADIX-1 that receives a carry rolls to 0.
  - en with up=0: digit 0 decrements. Digit i decrements only when all lower digits equal 0. Every digit at 0 that receives a borrow rolls to RADIX-1.
- Terminal state: all digits at RADIX-1 when up=1; all digits at 0 when up=0.
- carry = en & ~clr & ~load & terminal state.
- When carry is high:
  - SATURATE=0: count wraps (to all 0 going up, to all RADIX-1 going down).
  - SATURATE=1: count holds.
  - In both modes, ovf sets on that edge.
- up may change on any cycle. Direction is sampled on the same edge as en.
- Digit arithmetic is modulo RADIX within DW bits. Digit values >= RADIX are never stored.

## Timing

- count is registered and updates on the rising clk edge after en, clr or load is sampled.
- Latency is one cycle from input to count.
- carry is combinational from the registered count, en, up, clr and load. It is valid in the same cycle as the terminal step and precedes the wrap edge, so it can drive a downstream chain's en.
- ovf rises on the edge that consumes carry, i.e. one cycle after carry is seen.
- Reset asserted mid-count clears count and ovf immediately, without waiting for clk.
- Reset deassertion is synchronised externally. The first count step occurs on the first edge with rst_n high and en high.
- Simultaneous clr and load: clr wins, count = 0.
- Simultaneous load and en: load wins, with no extra step.

## Structure

- A shared package holds the digit-width helper function, the packed-digit index macro/function, and the SATURATE mode constants.
- One natural sub-module is bcd_digit: a single modulo-RADIX up/down digit.
  - Inputs: step, up, clr, load, load_digit.
  - Outputs: value, and at_limit (max when up, zero when down).
- The top module generates DIGITS instances of bcd_digit. Digit i's step input is en AND the at_limit outputs of all lower digits (ripple AND chain).
- The top module also owns carry, the saturation gating and ovf.

## Test plan

- Reset and count up: rst_n low then high, en=1, up=1 for 1234 cycles -> count = 16'h1234 (BCD), carry never high, ovf=0.
- Wrap up: load 9999, next cycle en=1 up=1 -> carry=1 in that cycle, then count=0000 and ovf=1.
- Wrap down: clr, then en=1 up=0 -> carry=1 at 0000, next count=9999 and ovf=1. Also decrement across a borrow: 1000 -> 0999.
- Saturate (SATURATE=1): load 9998, en=1 up=1 for 3 cycles -> counts 9999, 9999, 9999. carry is high on cycles 2 and 3; ovf=1.
- Priority and clamp:
  - load_val=16'h0A5F with load=1 and en=1 -> count=0959.
  - clr=1 and load=1 together -> count=0000 and ovf cleared.
- Async reset mid-operation: count running at 0421, pulse rst_n low between clock edges -> count=0000 and ovf=0 immediately. Counting resumes from 0001 after release.
- Parameter sweep: DIGITS=2, RADIX=16, DW=4, up from 0 for 256 cycles -> count returns to 00 with exactly one carry pulse.
